// File: rtl/gpu_pkg.sv
// Shared GPU display constants: the VGA 640x480 timing set and the line/frame
// total helper that the fetch unit also uses.
package gpu_pkg;

  localparam int VGA_H_DISPLAY = 640;
  localparam int VGA_H_FRONT   = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BACK    = 48;
  localparam int VGA_V_DISPLAY = 480;
  localparam int VGA_V_FRONT   = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BACK    = 33;

  function automatic int total(input int sync, input int back, input int disp, input int front);
    return sync + back + disp + front;
  endfunction

endpackage

// File: rtl/axis_timer.sv
// One raster axis: exact-period counter plus sync, visible-window and
// lookahead-window decode (region order: sync, back porch, display, front porch).
module axis_timer
  import gpu_pkg::*;
#(
  parameter int W           = 11,
  parameter int SYNC        = 1,
  parameter int BACK        = 1,
  parameter int DISP        = 1,
  parameter int FRONT       = 1,
  parameter int LEAD        = 0,
  parameter int SCALE_SHIFT = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         adv,
  output logic [W-1:0] cnt,
  output logic         wrap,
  output logic         in_sync,
  output logic         bright,
  output logic [W-1:0] pos,
  output logic [W-1:0] la_pos
);

  localparam int           TOTAL    = total(SYNC, BACK, DISP, FRONT);
  localparam logic [W-1:0] LAST     = W'(TOTAL - 1);
  localparam logic [W-1:0] SYNC_END = W'(SYNC);
  localparam logic [W-1:0] VIS_BEG  = W'(SYNC + BACK);
  localparam logic [W-1:0] VIS_END  = W'(TOTAL - FRONT);
  localparam logic [W-1:0] LA_BEG   = W'(SYNC + BACK - LEAD);
  localparam logic [W-1:0] LA_END   = W'(TOTAL - FRONT - LEAD);

  logic la_in;

  always_ff @(posedge clk) begin
    if (!rst || clr) cnt <= '0;
    else if (adv)    cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
  end

  assign wrap = adv && (cnt == LAST);

  always_comb begin
    in_sync = (cnt < SYNC_END);
    bright  = (cnt >= VIS_BEG) && (cnt < VIS_END);
    la_in   = (cnt >= LA_BEG) && (cnt < LA_END);
    pos     = bright ? ((cnt - VIS_BEG) >> SCALE_SHIFT) : '0;
    la_pos  = la_in  ? ((cnt - LA_BEG)  >> SCALE_SHIFT) : '0;
  end

endmodule

// File: rtl/video_timing.sv
// Parametrised raster timing generator: pixel-clock divider, horizontal and
// vertical axis timers, registered sync/flag/coordinate outputs and frame events.
module video_timing
  import gpu_pkg::*;
#(
  parameter int CLK_DIV     = 2,
  parameter int H_DISPLAY   = VGA_H_DISPLAY,
  parameter int H_FRONT     = VGA_H_FRONT,
  parameter int H_SYNC      = VGA_H_SYNC,
  parameter int H_BACK      = VGA_H_BACK,
  parameter int V_DISPLAY   = VGA_V_DISPLAY,
  parameter int V_FRONT     = VGA_V_FRONT,
  parameter int V_SYNC      = VGA_V_SYNC,
  parameter int V_BACK      = VGA_V_BACK,
  parameter bit HSYNC_POL   = 1'b0,
  parameter bit VSYNC_POL   = 1'b0,
  parameter int LOOKAHEAD   = 1,
  parameter int SCALE_SHIFT = 0,
  parameter int W           = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         run,
  output logic         pix_en,
  output logic [W-1:0] x,
  output logic [W-1:0] y,
  output logic [W-1:0] ly,
  output logic         field,
  output logic         hbright,
  output logic         vbright,
  output logic         bright,
  output logic         hsync,
  output logic         vsync,
  output logic         line_start,
  output logic         frame_start,
  output logic         vblank_irq,
  output logic [15:0]  frame_count
);

  localparam int            V_TOTAL  = total(V_SYNC, V_BACK, V_DISPLAY, V_FRONT);
  localparam logic [W-1:0]  V_IRQ    = W'(V_TOTAL - V_FRONT);
  localparam int            DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div;
  logic          tick;
  logic [W-1:0]  hc, vc, h_pos, v_pos, h_la_pos, v_la_pos;
  logic          h_wrap, v_wrap, h_sync, v_sync, h_bright, v_bright;
  logic          sof, seen;
  logic          unused_ok;

  assign tick = run && (div == DIV_LAST);

  always_ff @(posedge clk) begin
    if (!rst || !run) div <= '0;
    else              div <= tick ? '0 : div + 1'b1;
  end

  axis_timer #(
    .W(W), .SYNC(H_SYNC), .BACK(H_BACK), .DISP(H_DISPLAY), .FRONT(H_FRONT),
    .LEAD(0), .SCALE_SHIFT(SCALE_SHIFT)
  ) u_h (
    .clk(clk), .rst(rst), .clr(!run), .adv(tick), .cnt(hc), .wrap(h_wrap),
    .in_sync(h_sync), .bright(h_bright), .pos(h_pos), .la_pos(h_la_pos)
  );

  // Vertical axis steps once per completed line.
  axis_timer #(
    .W(W), .SYNC(V_SYNC), .BACK(V_BACK), .DISP(V_DISPLAY), .FRONT(V_FRONT),
    .LEAD(LOOKAHEAD), .SCALE_SHIFT(SCALE_SHIFT)
  ) u_v (
    .clk(clk), .rst(rst), .clr(!run), .adv(h_wrap), .cnt(vc), .wrap(v_wrap),
    .in_sync(v_sync), .bright(v_bright), .pos(v_pos), .la_pos(v_la_pos)
  );

  assign unused_ok = ^{h_la_pos, v_wrap};
  assign sof       = (hc == '0) && (vc == '0);

  // Output stage: capture decode of the current (hc, vc) on each tick.
  always_ff @(posedge clk) begin
    if (!rst || !run) begin
      pix_en      <= 1'b0;
      x           <= '0;
      y           <= '0;
      ly          <= '0;
      field       <= 1'b0;
      hbright     <= 1'b0;
      vbright     <= 1'b0;
      bright      <= 1'b0;
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      vblank_irq  <= 1'b0;
    end else begin
      pix_en      <= tick;
      line_start  <= tick && (hc == '0);
      frame_start <= tick && sof;
      vblank_irq  <= tick && (hc == '0) && (vc == V_IRQ);
      if (tick) begin
        x       <= h_pos;
        y       <= v_pos;
        ly      <= v_la_pos;
        field   <= v_la_pos[0];
        hbright <= h_bright;
        vbright <= v_bright;
        bright  <= h_bright && v_bright;
        hsync   <= h_sync ? HSYNC_POL : ~HSYNC_POL;
        vsync   <= v_sync ? VSYNC_POL : ~VSYNC_POL;
      end
    end
  end

  // The first frame_start after reset or run rise only arms the counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      frame_count <= '0;
      seen        <= 1'b0;
    end else if (!run) begin
      seen <= 1'b0;
    end else if (tick && sof) begin
      seen <= 1'b1;
      if (seen) frame_count <= frame_count + 16'd1;
    end
  end

endmodule
